// File: rtl/asym_width_fifo_ctrl.sv
// Width-up-converting FIFO controller for a simple-dual-port asymmetric RAM: narrow writes, wide reads.
// Owns pointers, occupancy, flags, read-valid pipeline and sticky errors; the RAM datapath lives outside.
module asym_width_fifo_ctrl #(
    parameter int C_WR_WIDTH     = 16,
    parameter int C_RD_WIDTH     = 32,
    parameter int C_WR_DEPTH     = 1024,
    parameter int C_RD_LATENCY   = 1,
    parameter int C_AFULL_THRESH = 1000,
    localparam int RATIO    = C_RD_WIDTH / C_WR_WIDTH,
    localparam int RD_DEPTH = C_WR_DEPTH / RATIO,
    localparam int WA       = $clog2(C_WR_DEPTH),
    localparam int RA       = $clog2(RD_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_req,
    output logic          wr_ready,
    output logic [WA-1:0] ram_wrAddr,
    output logic          ram_wren,
    input  logic          rd_req,
    output logic          rd_ready,
    output logic [RA-1:0] ram_rdAddr,
    output logic          ram_rden,
    output logic          rd_valid,
    output logic [15:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          wr_overflow,
    output logic          rd_underflow
);
    localparam logic [15:0] DEPTH_W = 16'(C_WR_DEPTH);
    localparam logic [15:0] RATIO_W = 16'(RATIO);
    localparam logic [15:0] AFULL_W = 16'(C_AFULL_THRESH);

    logic [WA-1:0]           wr_ptr;
    logic [RA-1:0]           rd_ptr;
    logic [C_RD_LATENCY-1:0] vld_pipe;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [15:0]             count_nxt;

    // Count (not pointer comparison) decides full/empty, so both pointers wrap freely.
    // A read needs RATIO narrow words present, so a half-filled wide slot is never read.
    assign wr_ready   = !full;
    assign rd_ready   = (count >= RATIO_W);
    assign wr_acc     = wr_req && !full && !flush;
    assign rd_acc     = rd_req && rd_ready && !flush;
    assign ram_wren   = wr_acc;
    assign ram_wrAddr = wr_ptr;
    assign ram_rden   = rd_acc;
    assign ram_rdAddr = rd_ptr;
    assign rd_valid   = vld_pipe[C_RD_LATENCY-1];

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b11:   count_nxt = count + 16'd1 - RATIO_W;
            2'b10:   count_nxt = count + 16'd1;
            2'b01:   count_nxt = count - RATIO_W;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            vld_pipe     <= '0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            vld_pipe     <= '0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            full        <= (count_nxt == DEPTH_W);
            empty       <= (count_nxt == 16'd0);
            almost_full <= (count_nxt >= AFULL_W);
            vld_pipe[0] <= rd_acc;
            for (int i = 1; i < C_RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (wr_req && full)      wr_overflow  <= 1'b1;
            if (rd_req && !rd_ready) rd_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_asym_width_fifo_ctrl.sv
// Bench for asym_width_fifo_ctrl: two instances (read latency 1 and 3) share stimulus and each drives a RAM model.
module tb_asym_width_fifo_ctrl;
    logic clk, rst, flush, wr_req, rd_req;
    logic [15:0] wdat;

    logic        wr_ready1, ram_wren1, rd_ready1, ram_rden1, rd_valid1;
    logic        full1, empty1, almost_full1, wr_overflow1, rd_underflow1;
    logic [2:0]  ram_wrAddr1;
    logic [1:0]  ram_rdAddr1;
    logic [15:0] count1;
    logic        wr_ready3, ram_wren3, rd_ready3, ram_rden3, rd_valid3;
    logic        full3, empty3, almost_full3, wr_overflow3, rd_underflow3;
    logic [2:0]  ram_wrAddr3;
    logic [1:0]  ram_rdAddr3;
    logic [15:0] count3;

    asym_width_fifo_ctrl #(.C_WR_WIDTH(16), .C_RD_WIDTH(32), .C_WR_DEPTH(8),
                           .C_RD_LATENCY(1), .C_AFULL_THRESH(6)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .wr_ready(wr_ready1),
        .ram_wrAddr(ram_wrAddr1), .ram_wren(ram_wren1), .rd_req(rd_req), .rd_ready(rd_ready1),
        .ram_rdAddr(ram_rdAddr1), .ram_rden(ram_rden1), .rd_valid(rd_valid1), .count(count1),
        .full(full1), .empty(empty1), .almost_full(almost_full1),
        .wr_overflow(wr_overflow1), .rd_underflow(rd_underflow1));

    asym_width_fifo_ctrl #(.C_WR_WIDTH(16), .C_RD_WIDTH(32), .C_WR_DEPTH(8),
                           .C_RD_LATENCY(3), .C_AFULL_THRESH(6)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .wr_ready(wr_ready3),
        .ram_wrAddr(ram_wrAddr3), .ram_wren(ram_wren3), .rd_req(rd_req), .rd_ready(rd_ready3),
        .ram_rdAddr(ram_rdAddr3), .ram_rden(ram_rden3), .rd_valid(rd_valid3), .count(count3),
        .full(full3), .empty(empty3), .almost_full(almost_full3),
        .wr_overflow(wr_overflow3), .rd_underflow(rd_underflow3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asymmetric RAM models: lane 0 (even narrow address) is the low half of the wide word.
    logic [15:0] mem1 [0:7];
    logic [15:0] mem3 [0:7];
    logic [31:0] dout1, dout3, p0, p1;
    always @(posedge clk) begin
        if (ram_wren1) mem1[ram_wrAddr1] <= wdat;
        if (ram_rden1) dout1 <= {mem1[{ram_rdAddr1, 1'b1}], mem1[{ram_rdAddr1, 1'b0}]};
        if (ram_wren3) mem3[ram_wrAddr3] <= wdat;
        if (ram_rden3) p0 <= {mem3[{ram_rdAddr3, 1'b1}], mem3[{ram_rdAddr3, 1'b0}]};
        p1    <= p0;
        dout3 <= p1;
    end

    int passed = 0;
    int total  = 0;
    logic [31:0] exp1[$];
    logic [31:0] exp3[$];
    logic [15:0] nq[$];
    int mcnt = 0, mwr = 0, mrd = 0;
    logic mov = 1'b0, mund = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitors: every rd_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!rst && rd_valid1) begin
            if (exp1.size() == 0) chk("rd_valid1_spurious", rd_valid1, 1'b0);
            else chk("dout1", dout1, exp1.pop_front());
        end
        if (!rst && rd_valid3) begin
            if (exp3.size() == 0) chk("rd_valid3_spurious", rd_valid3, 1'b0);
            else chk("dout3", dout3, exp3.pop_front());
        end
    end

    task automatic clear_model();
        mcnt = 0; mwr = 0; mrd = 0; mov = 1'b0; mund = 1'b0;
        nq.delete(); exp1.delete(); exp3.delete();
    endtask

    // One cycle: drive requests, check accept strobes/addresses, then check registered state.
    task automatic op(input logic w, input logic r, input logic f, input logic [15:0] d,
                      input int exp_cnt);
        logic wa, ra;
        logic [15:0] lo, hi;
        wr_req = w; rd_req = r; flush = f; wdat = d;
        wa = w && !f && (mcnt != 8);
        ra = r && !f && (mcnt >= 2);
        #1;
        chk("ram_wren", ram_wren1, wa);
        chk("ram_rden", ram_rden1, ra);
        if (wa) chk("ram_wrAddr", ram_wrAddr1, mwr);
        if (ra) chk("ram_rdAddr", ram_rdAddr1, mrd);
        if (!f && w && mcnt == 8) mov = 1'b1;
        if (!f && r && mcnt < 2)  mund = 1'b1;
        if (wa) begin nq.push_back(d); mwr = (mwr + 1) % 8; end
        if (ra) begin
            lo = nq.pop_front(); hi = nq.pop_front();
            exp1.push_back({hi, lo}); exp3.push_back({hi, lo});
            mrd = (mrd + 1) % 4;
        end
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
        if (f) clear_model();
        else mcnt = exp_cnt;
        chk("count", count1, exp_cnt);
        chk("count_lat3", count3, exp_cnt);
        chk("full", full1, exp_cnt == 8);
        chk("empty", empty1, exp_cnt == 0);
        chk("almost_full", almost_full1, exp_cnt >= 6);
        chk("wr_ready", wr_ready1, exp_cnt != 8);
        chk("rd_ready", rd_ready1, exp_cnt >= 2);
        chk("wr_overflow", wr_overflow1, mov);
        chk("rd_underflow", rd_underflow1, mund);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count1, 0);
        chk({tag, "_empty"}, empty1, 1);
        chk({tag, "_full"}, full1, 0);
        chk({tag, "_afull"}, almost_full1, 0);
        chk({tag, "_wr_ready"}, wr_ready1, 1);
        chk({tag, "_rd_ready"}, rd_ready1, 0);
        chk({tag, "_ram_wren"}, ram_wren1, 0);
        chk({tag, "_ram_rden"}, ram_rden1, 0);
        chk({tag, "_rd_valid1"}, rd_valid1, 0);
        chk({tag, "_rd_valid3"}, rd_valid3, 0);
        chk({tag, "_wr_overflow"}, wr_overflow1, 0);
        chk({tag, "_rd_underflow"}, rd_underflow1, 0);
        chk({tag, "_count3"}, count3, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wdat = '0;
        #12;
        chk_reset_state("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic conversion: 0xA1, 0xB2 pack into 0x00B200A1.
        op(1, 0, 0, 16'h00A1, 1);
        op(1, 0, 0, 16'h00B2, 2);
        op(0, 1, 0, 16'h0000, 0);
        chk("lat1_valid_now", rd_valid1, 1);
        chk("lat3_valid_early", rd_valid3, 0);
        op(0, 0, 0, 16'h0000, 0);
        chk("lat1_single_pulse", rd_valid1, 0);
        op(0, 0, 0, 16'h0000, 0);
        chk("lat3_valid_now", rd_valid3, 1);
        op(0, 0, 0, 16'h0000, 0);

        // Fill to full, then one refused write.
        for (int i = 0; i < 8; i++) op(1, 0, 0, 16'h0010 + 16'(i), i + 1);
        op(1, 0, 0, 16'h00EE, 8);

        // Simultaneous at full: read proceeds, write refused.
        op(1, 1, 0, 16'h0099, 6);

        // Drain to 3, then simultaneous at count 3 and at count == RATIO.
        op(0, 1, 0, 16'h0000, 4);
        op(0, 1, 0, 16'h0000, 2);
        op(1, 0, 0, 16'h0020, 3);
        op(1, 1, 0, 16'h0021, 2);
        op(1, 1, 0, 16'h0022, 1);

        // Underflow at count 1, then flush with requests held high.
        op(0, 1, 0, 16'h0000, 1);
        op(1, 1, 1, 16'h0077, 0);

        // 20 writes interleaved with 10 reads: both pointers wrap.
        for (int i = 0; i < 10; i++) begin
            op(1, 0, 0, 16'h0100 + 16'(2*i), 1);
            op(1, 0, 0, 16'h0101 + 16'(2*i), 2);
            op(0, 1, 0, 16'h0000, 0);
        end
        for (int i = 0; i < 4; i++) op(0, 0, 0, 16'h0000, 0);

        // Flush the cycle after a read: the latency-3 pulse must never appear.
        op(1, 0, 0, 16'h0055, 1);
        op(1, 0, 0, 16'h0066, 2);
        op(0, 1, 0, 16'h0000, 0);
        op(0, 0, 1, 16'h0000, 0);
        for (int i = 0; i < 4; i++) op(0, 0, 0, 16'h0000, 0);

        // Asynchronous reset between edges while the latency-3 pulse is up.
        op(1, 0, 0, 16'h00AB, 1);
        op(1, 0, 0, 16'h00CD, 2);
        op(1, 1, 0, 16'h00EF, 1);
        op(0, 1, 0, 16'h0000, 1);
        op(0, 0, 0, 16'h0000, 1);
        chk("pre_rst_valid3", rd_valid3, 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        clear_model();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) op(0, 0, 0, 16'h0000, 0);

        chk("exp1_drained", 32'(exp1.size()), 0);
        chk("exp3_drained", 32'(exp3.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end
endmodule
